// File: rtl/branch_target_unit.sv
// ID-stage BEQ/BNE resolver: target = pc_plus4 + off_sh, redirect issued 1 cycle after accept, then a 1-cycle IF/ID flush.
// Backpressure: in_ready is low outside IDLE (the candidate stalls upstream); the redirect holds until redir_ready.
module branch_target_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_beq,
  input  logic             is_bne,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  off_sh,
  input  logic [XLEN-1:0]  rs_val,
  input  logic [XLEN-1:0]  rt_val,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [XLEN-1:0]  redir_target,
  output logic             align_err,
  output logic             flush_ifid,
  output logic             stall_id,
  output logic [CNT_W-1:0] taken_cnt,
  output logic             dec_err
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t            state_q;
  logic              redir_valid_q;
  logic [XLEN-1:0]   redir_target_q;
  logic              align_err_q;
  logic              flush_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              dec_err_q;

  logic              accept;
  logic              taken;
  logic              ops_eq;
  logic [XLEN-1:0]   tgt;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign stall_id = in_valid && !in_ready;
  assign ops_eq   = (rs_val == rt_val);
  // Carry-out is dropped on purpose: targets wrap modulo 2^XLEN.
  assign tgt      = pc_plus4 + off_sh;
  assign taken    = (is_beq && !is_bne && ops_eq) || (is_bne && !is_beq && !ops_eq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      redir_valid_q  <= 1'b0;
      redir_target_q <= '0;
      align_err_q    <= 1'b0;
      flush_q        <= 1'b0;
      cnt_q          <= '0;
      dec_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_beq && is_bne) begin
              dec_err_q <= 1'b1;
            end
            if (taken) begin
              state_q        <= REDIRECT;
              redir_valid_q  <= 1'b1;
              redir_target_q <= tgt;
              align_err_q    <= |tgt[1:0];
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
        end
        REDIRECT: begin
          // Target and align_err stay put until fetch takes the redirect.
          if (redir_ready) begin
            state_q       <= FLUSH;
            redir_valid_q <= 1'b0;
            flush_q       <= 1'b1;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state_q       <= IDLE;
          redir_valid_q <= 1'b0;
          flush_q       <= 1'b0;
        end
      endcase
    end
  end

  assign redir_valid  = redir_valid_q;
  assign redir_target = redir_target_q;
  assign align_err    = align_err_q;
  assign flush_ifid   = flush_q;
  assign taken_cnt    = cnt_q;
  assign dec_err      = dec_err_q;

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: a vector table plus hand-written backpressure and reset sequences.
// A second instance with CNT_W=2 shares the stimulus and exercises counter saturation.
module tb_branch_target_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        is_beq;
  logic        is_bne;
  logic [31:0] pc_plus4;
  logic [31:0] off_sh;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        redir_ready;

  logic        in_ready, redir_valid, align_err, flush_ifid, stall_id, dec_err;
  logic [31:0] redir_target;
  logic [15:0] taken_cnt;

  logic        s_in_ready, s_redir_valid, s_align_err, s_flush_ifid, s_stall_id, s_dec_err;
  logic [31:0] s_redir_target;
  logic [1:0]  s_taken_cnt;

  branch_target_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .is_beq(is_beq), .is_bne(is_bne), .pc_plus4(pc_plus4), .off_sh(off_sh),
    .rs_val(rs_val), .rt_val(rt_val), .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_target(redir_target), .align_err(align_err), .flush_ifid(flush_ifid),
    .stall_id(stall_id), .taken_cnt(taken_cnt), .dec_err(dec_err)
  );

  branch_target_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .is_beq(is_beq), .is_bne(is_bne), .pc_plus4(pc_plus4), .off_sh(off_sh),
    .rs_val(rs_val), .rt_val(rt_val), .redir_valid(s_redir_valid), .redir_ready(redir_ready),
    .redir_target(s_redir_target), .align_err(s_align_err), .flush_ifid(s_flush_ifid),
    .stall_id(s_stall_id), .taken_cnt(s_taken_cnt), .dec_err(s_dec_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        beq;
    logic        bne;
    logic [31:0] pc;
    logic [31:0] off;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        taken;
    logic [31:0] tgt;
    logic        align;
  } vec_t;

  vec_t vecs[9];

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  logic exp_dec = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic set_in(input logic v, input logic b, input logic n, input logic [31:0] pc,
                        input logic [31:0] off, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v; is_beq = b; is_bne = n; pc_plus4 = pc; off_sh = off; rs_val = rs; rt_val = rt;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    set_in(1'b1, v.beq, v.bne, v.pc, v.off, v.rs, v.rt);
    redir_ready = 1'b1;
    @(negedge clk);
    chk({v.name, "/in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (v.taken) exp_cnt++;
    if (v.beq && v.bne) exp_dec = 1'b1;
    @(negedge clk);
    chk({v.name, "/redir_valid"}, 32'(redir_valid), 32'(v.taken));
    if (v.taken) begin
      chk({v.name, "/target"}, redir_target, v.tgt);
      chk({v.name, "/align_err"}, 32'(align_err), 32'(v.align));
    end
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "/flush"}, 32'(flush_ifid), 32'(v.taken));
    @(posedge clk);
    @(negedge clk);
    chk({v.name, "/idle_ready"}, 32'(in_ready), 32'd1);
    chk({v.name, "/taken_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
    chk({v.name, "/sat_cnt"}, 32'(s_taken_cnt), 32'(sat3(exp_cnt)));
    chk({v.name, "/dec_err"}, 32'(dec_err), 32'(exp_dec));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"t1_beq_taken",  1'b1, 1'b0, 32'h0040_0004, 32'h0000_0010, 32'd5, 32'd5, 1'b1, 32'h0040_0014, 1'b0};
    vecs[1] = '{"t2_bne_not",    1'b0, 1'b1, 32'h0040_0004, 32'h0000_0010, 32'd7, 32'd7, 1'b0, 32'h0,        1'b0};
    vecs[2] = '{"t3_backward",   1'b1, 1'b0, 32'h0000_0004, 32'hFFFF_FFF8, 32'd1, 32'd1, 1'b1, 32'hFFFF_FFFC, 1'b0};
    vecs[3] = '{"t3_wrap",       1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0008, 32'd1, 32'd2, 1'b1, 32'h0000_0004, 1'b0};
    vecs[4] = '{"t5_align",      1'b1, 1'b0, 32'h0000_0002, 32'h0000_0000, 32'd9, 32'd9, 1'b1, 32'h0000_0002, 1'b1};
    vecs[5] = '{"beq_not",       1'b1, 1'b0, 32'h0000_1000, 32'h0000_0040, 32'd3, 32'd4, 1'b0, 32'h0,        1'b0};
    vecs[6] = '{"bne_taken_neg", 1'b0, 1'b1, 32'h0000_1000, 32'hFFFF_FF00, 32'd0, 32'd1, 1'b1, 32'h0000_0F00, 1'b0};
    vecs[7] = '{"t5_dec_err",    1'b1, 1'b1, 32'h0000_2000, 32'h0000_0010, 32'd6, 32'd6, 1'b0, 32'h0,        1'b0};
    vecs[8] = '{"no_branch",     1'b0, 1'b0, 32'h0000_2000, 32'h0000_0010, 32'd6, 32'd6, 1'b0, 32'h0,        1'b0};

    rst_n = 1'b0;
    redir_ready = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst/redir_valid", 32'(redir_valid), 32'd0);
    chk("rst/target", redir_target, 32'd0);
    chk("rst/flush", 32'(flush_ifid), 32'd0);
    chk("rst/cnt", 32'(taken_cnt), 32'd0);
    chk("rst/dec_err", 32'(dec_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst/in_ready", 32'(in_ready), 32'd1);
    // redir_ready with no pending redirect must not start a flush
    redir_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready/flush", 32'(flush_ifid), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: redirect held for 3 cycles while a new candidate stalls upstream.
    @(posedge clk); #1;
    redir_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0020, 32'd4, 32'd4);
    @(posedge clk); #1;
    exp_cnt++;
    set_in(1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0004, 32'd8, 32'd8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4/hold_valid", 32'(redir_valid), 32'd1);
      chk("t4/hold_target", redir_target, 32'h0000_0120);
      chk("t4/stall_id", 32'(stall_id), 32'd1);
      chk("t4/no_flush", 32'(flush_ifid), 32'd0);
      @(posedge clk); #1;
    end
    redir_ready = 1'b1;
    @(negedge clk);
    chk("t4/still_valid", 32'(redir_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t4/flush", 32'(flush_ifid), 32'd1);
    chk("t4/valid_drop", 32'(redir_valid), 32'd0);
    chk("t4/stall_flush", 32'(stall_id), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t4/flush_once", 32'(flush_ifid), 32'd0);
    chk("t4/in_ready", 32'(in_ready), 32'd1);
    chk("t4/unstall", 32'(stall_id), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t4/held_not_taken", 32'(redir_valid), 32'd0);
    chk("t4/cnt", 32'(taken_cnt), 32'(exp_cnt));
    chk("t5/sat_cnt", 32'(s_taken_cnt), 32'd3);
    chk("t5/dec_sticky", 32'(dec_err), 32'd1);

    // Reset asserted mid-REDIRECT clears everything asynchronously.
    @(posedge clk); #1;
    redir_ready = 1'b0;
    set_in(1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0004, 32'd1, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6/pre_valid", 32'(redir_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6/async_valid", 32'(redir_valid), 32'd0);
    chk("t6/async_target", redir_target, 32'd0);
    chk("t6/async_cnt", 32'(taken_cnt), 32'd0);
    chk("t6/async_dec", 32'(dec_err), 32'd0);
    chk("t6/async_align", 32'(align_err), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    redir_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t6/no_flush", 32'(flush_ifid), 32'd0);
      chk("t6/in_ready", 32'(in_ready), 32'd1);
      chk("t6/no_valid", 32'(redir_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
